vga_timing: RTL
===============

# vga_timing

Generates the 640x480@60 Hz VGA raster for the display path. It drives the row/column coordinates (`r`, `c`) consumed by the window/quadrant logic and framebuffer address concatenation, together with the sync pulses and active-video flag sent to the DAC/connector. It runs from the 50 MHz board clock and advances one pixel per internal pixel-enable strobe, by default every second clock.

## Interface
- `CLK_DIV`, 2: board clocks per pixel; legal values ≥ 1; 1 means a pixel on every clock.
- `clk`  input  1  board clock; all state changes on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `pix_en`  output  1  one-cycle strobe; the counters advance on edges where it is 1.
- `c`  output  10  column counter, 0..799.
- `r`  output  10  row counter, 0..524.
- `active`  output  1  1 when `c` ≤ 639 and `r` ≤ 479.
- `hsync`  output  1  active-low horizontal sync.
- `vsync`  output  1  active-low vertical sync.
- `frame_start`  output  1  one-`pix_en`-period pulse while (`r`,`c`) = (0,0) after a wrap.

## Operation
- Divider
  - `div` counts 0..CLK_DIV-1 and wraps.
  - `pix_en` = (`div` == CLK_DIV-1), decoded combinationally.
  - With CLK_DIV = 1, `pix_en` is held at 1.
- Horizontal, on `pix_en`
  - `c` increments and wraps 799 → 0.
  - Regions: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical
  - `r` increments only on `pix_en` with `c` == 799; wraps 524 → 0.
  - Regions: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Flags
  - `hsync` = 0 iff 656 ≤ `c` ≤ 751.
  - `vsync` = 0 iff 490 ≤ `r` ≤ 491.
  - `hsync`, `vsync` and `active` are registered: computed from the next-state counter values, so all outputs change on the same edge as `c`/`r`. No combinational glitches on the sync outputs.
- `frame_start`
  - Registered; set on the edge where (`r`,`c`) wraps from (524,799) to (0,0).
  - Cleared on the next `pix_en` edge.
  - Not asserted by reset.
- No other states. The block is a free-running pair of nested counters; there are no inputs besides clock and reset.

## Timing
- Reset values (asynchronous, immediate on `rst_n` falling):
  - `div` = 0, `c` = 0, `r` = 0.
  - `active` = 1, `hsync` = 1, `vsync` = 1, `frame_start` = 0.
- First `pix_en` comes CLK_DIV-1 clocks after reset release. `c` becomes 1 on that edge.
- Line = 800 × CLK_DIV clocks; frame = 525 lines = 420000 × CLK_DIV clocks.
- Latency: flags are aligned with `c`/`r` (zero cycles). Downstream pixel pipelines compensate for their own delay.
- Reset mid-line or mid-frame: all state returns to reset values at once. A sync pulse in progress ends immediately (`hsync`/`vsync` go to 1).
- Simultaneous events: on the (524,799) `pix_en` edge, `c`, `r` and `frame_start` update together. `vsync` and `hsync` are already 1 there.

## Structure
- Package `vga_pkg`:
  - Localparams H_VISIBLE=640, H_FP=16, H_SYNC=96, H_BP=48, V_VISIBLE=480, V_FP=10, V_SYNC=2, V_BP=33.
  - Derived H_TOTAL=800 and V_TOTAL=525.
  - `typedef logic [9:0] coord_t`.
- Sub-module `clk_en_div` (parameter `DIV`; ports `clk`, `rst_n`, `en`) produces `pix_en`.
- Counters and flag registers live in `vga_timing`.

## Test plan
- Reset held, then released (CLK_DIV=2) → `pix_en` first high at clock 1; `c`=1 after that edge; `r`=0; `hsync`=`vsync`=`active`=1.
- Run one line → `active` falls when `c`=640; `hsync`=0 exactly for `c` 656..751 (96 pixels = 192 clocks); `r` becomes 1 when `c` wraps 799→0.
- Run one frame → `vsync`=0 for `r` 490..491 (1600 pixels); `active`=0 for all `r` ≥ 480; `frame_start` high for exactly 2 clocks after 840000 clocks.
- CLK_DIV=1 → `pix_en` constant 1; frame period 420000 clocks; `frame_start` width 1 clock.
- Assert `rst_n`=0 asynchronously at `c`=700, `r`=491 → outputs return to reset values before the next clock edge; counting restarts from (0,0).
- Check `active` against the window logic → `active` equals (`r` ≤ 479 && `c` ≤ 639) on every clock over a full frame.

Source files
------------

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared raster geometry for the 640x480@60 Hz VGA timing path.
//   H_* : horizontal region widths in pixels (visible, front porch, sync, back porch)
//   V_* : vertical region heights in lines
//   H_TOTAL / V_TOTAL : full line / frame lengths
//   coord_t : row/column coordinate type used by the display path
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;  // 800
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;  // 525

  typedef logic [9:0] coord_t;

  // True when lo <= v <= hi (inclusive window test on a coordinate).
  function automatic logic in_window(input coord_t v, input int lo, input int hi);
    return (v >= coord_t'(lo)) && (v <= coord_t'(hi));
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// ---------------------------------------------------------------------------
// clk_en_div
// Clock-enable divider: produces a one-clock strobe every DIV clocks.
//   clk   : board clock
//   rst_n : asynchronous active-low reset (counter returns to 0)
//   en    : strobe, high while the divider count equals DIV-1
// With DIV = 1 the count is pinned at 0, which equals DIV-1, so en stays high.
// ---------------------------------------------------------------------------
module clk_en_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic en
);

  // At least one bit so the DIV = 1 case still elaborates cleanly.
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (div == LAST) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Decoded combinationally so the strobe lines up with the counter value.
  assign en = (div == LAST);

endmodule

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Free-running VGA raster generator (default 640x480@60 Hz from a 50 MHz
// clock with CLK_DIV = 2). Column and row counters advance on the pixel
// strobe; sync/active/frame flags are registered from the next-state
// counter values so every output changes on the same edge as c/r.
//   clk         : board clock
//   rst_n       : asynchronous active-low reset
//   pix_en      : one-clock pixel strobe
//   c, r        : column 0..H_TOTAL-1, row 0..V_TOTAL-1
//   active      : visible-area flag
//   hsync/vsync : active-low sync pulses
//   frame_start : one pixel-period pulse while at (0,0) after a frame wrap
// The geometry parameters default to the standard mode; they exist so the
// same counter structure can drive other raster sizes.
// ---------------------------------------------------------------------------
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int H_ACT   = H_VISIBLE,
  parameter int H_FRONT = H_FP,
  parameter int H_PULSE = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_ACT   = V_VISIBLE,
  parameter int V_FRONT = V_FP,
  parameter int V_PULSE = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_en,
  output logic [9:0] c,
  output logic [9:0] r,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int HT  = H_ACT + H_FRONT + H_PULSE + H_BACK;
  localparam int VT  = V_ACT + V_FRONT + V_PULSE + V_BACK;
  localparam int HS0 = H_ACT + H_FRONT;
  localparam int HS1 = HS0 + H_PULSE - 1;
  localparam int VS0 = V_ACT + V_FRONT;
  localparam int VS1 = VS0 + V_PULSE - 1;

  coord_t c_reg, c_next;
  coord_t r_reg, r_next;
  logic   active_reg, hsync_reg, vsync_reg, frame_start_reg;
  logic   line_end, frame_end;

  clk_en_div #(
    .DIV (CLK_DIV)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en)
  );

  // Next-state counter values; only applied on pix_en.
  always_comb begin
    line_end  = (c_reg == coord_t'(HT - 1));
    frame_end = line_end && (r_reg == coord_t'(VT - 1));
    c_next    = line_end ? '0 : c_reg + 10'd1;
    r_next    = r_reg;
    if (line_end) begin
      r_next = (r_reg == coord_t'(VT - 1)) ? '0 : r_reg + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_reg           <= '0;
      r_reg           <= '0;
      active_reg      <= 1'b1;  // (0,0) is inside the visible window
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      frame_start_reg <= 1'b0;
    end else if (pix_en) begin
      c_reg           <= c_next;
      r_reg           <= r_next;
      // Flags decoded from the values the counters are about to take, so
      // they are aligned with c/r and come straight from flops.
      active_reg      <= in_window(c_next, 0, H_ACT - 1) && in_window(r_next, 0, V_ACT - 1);
      hsync_reg       <= !in_window(c_next, HS0, HS1);
      vsync_reg       <= !in_window(r_next, VS0, VS1);
      // Set on the wrap edge, cleared on the following pixel strobe.
      frame_start_reg <= frame_end;
    end
  end

  assign c           = c_reg;
  assign r           = r_reg;
  assign active      = active_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign frame_start = frame_start_reg;

endmodule
